// File: rtl/pf_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pf_fetch_ctrl
// Purpose  : Pre-fetch stage controller. Owns PF_PC and loads it from NPC.
//            Issues single-outstanding requests on the SRAM-like inst_* bus.
//            Drops responses made stale by a redirect. Holds the fetched
//            instruction in a skid register until IF accepts it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   NPC           : next fetch address, consumed as-is
//   PCWr          : PC write enable; 0 blocks new requests only
//   PF_Flush      : redirect; load NPC, cancel any in-flight/buffered fetch
//   PF_PC         : address of the request being or about to be issued
//   inst_req/addr : request valid / address (combinational)
//   inst_addr_ok  : request accepted this cycle
//   inst_data_ok  : response valid this cycle, data on inst_rdata
//   IF_allowin    : IF stage can take the buffered instruction
//   IF_valid/PC/inst/adel : buffered instruction towards IF
// Configuration
//   PF_ADEL_CHECK_EN : when defined, a misaligned PF_PC is not issued on the
//                      bus; an address-error entry (IF_adel=1) is handed to IF
//                      instead. When undefined, IF_adel is constant 0.
// ============================================================================
module pf_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPC,
  input  logic        PCWr,
  input  logic        PF_Flush,
  output logic [31:0] PF_PC,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        IF_allowin,
  output logic        IF_valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_inst,
  output logic        IF_adel
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issue request
    S_WAIT = 2'd1,  // accepted, awaiting data
    S_HOLD = 2'd2,  // instruction buffered for IF
    S_DROP = 2'd3   // awaiting a stale response to discard
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pf_pc_q, pf_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_adel_q, if_adel_d;

  logic        adel_fire;
  logic        accept;

`ifdef PF_ADEL_CHECK_EN
  // A misaligned fetch that would otherwise be issued becomes an
  // address-error entry for IF instead of a bus request.
  assign adel_fire = (state_q == S_REQ) && PCWr && (pf_pc_q[1:0] != 2'b00);
`else
  assign adel_fire = 1'b0;
`endif

  // Request is suppressed while reset is asserted so nothing leaks onto the
  // bus before the state is known.
  assign inst_req  = (state_q == S_REQ) && PCWr && !adel_fire && !rst;
  assign inst_addr = pf_pc_q;
  assign accept    = inst_req && inst_addr_ok;

  assign PF_PC    = pf_pc_q;
  assign IF_valid = if_valid_q;
  assign IF_PC    = if_pc_q;
  assign IF_inst  = if_inst_q;
  assign IF_adel  = if_adel_q;

  always_comb begin
    state_d    = state_q;
    pf_pc_d    = pf_pc_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_adel_d  = if_adel_q;

    if (PF_Flush) begin
      // Redirect wins over every other event. Whatever is in flight or
      // buffered is now stale; only an outstanding bus response still has
      // to be absorbed (DROP) before the next request may go out.
      pf_pc_d    = NPC;
      if_valid_d = 1'b0;
      if_adel_d  = 1'b0;
      case (state_q)
        S_REQ:   state_d = accept ? S_DROP : S_REQ;
        S_WAIT:  state_d = inst_data_ok ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = inst_data_ok ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (adel_fire) begin
            if_valid_d = 1'b1;
            if_adel_d  = 1'b1;
            if_pc_d    = pf_pc_q;
            if_inst_d  = 32'h0000_0000;
            state_d    = S_HOLD;
          end else if (accept) begin
            req_pc_d = pf_pc_q;
            pf_pc_d  = NPC;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if_inst_d  = inst_rdata;
            if_pc_d    = req_pc_q;
            if_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (IF_allowin) begin
            if_valid_d = 1'b0;
            if_adel_d  = 1'b0;
            state_d    = S_REQ;
          end
        end
        S_DROP: begin
          if (inst_data_ok) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pf_pc_q    <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= 32'h0000_0000;
      if_adel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pf_pc_q    <= pf_pc_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_adel_q  <= if_adel_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pf_fetch_ctrl.md
# pf_fetch_ctrl

Pre-fetch (PF) stage controller on the consuming side of the next-PC interface. It owns the PF_PC register and loads it from NPC under PCWr/PF_Flush. It issues single-outstanding instruction requests on the SRAM-like `inst_*` bus and drops responses made stale by redirects. Fetched instructions are held in a skid register for the IF stage.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous and active-high
- NPC  input  32  next fetch address; PF_PC+4 when sequential
- PCWr  input  1  PC write enable; 0 = stall, no new request issued
- PF_Flush  input  1  redirect: load NPC, cancel in-flight fetch
- PF_PC  output  32  address of the request being or about to be issued
- inst_req  output  1  request valid
- inst_addr  output  32  request address, equals PF_PC
- inst_addr_ok  input  1  request accepted this cycle
- inst_data_ok  input  1  response data valid this cycle
- inst_rdata  input  32  response data
- IF_allowin  input  1  IF stage can accept an instruction
- IF_valid  output  1  IF_inst/IF_PC valid
- IF_PC  output  32  address of IF_inst
- IF_inst  output  32  fetched instruction
- IF_adel  output  1  fetch address misaligned; only with PF_ADEL_CHECK_EN, else tied 0

## Operation
- States:
  - REQ: issue request
  - WAIT: accepted, awaiting data
  - HOLD: instruction buffered for IF
  - DROP: awaiting a stale response to discard
- At most one request outstanding at any time.
- REQ:
  - inst_req = PCWr.
  - On inst_req && inst_addr_ok: req_pc <= PF_PC, PF_PC <= NPC, go WAIT.
- WAIT:
  - On inst_data_ok: IF_inst <= inst_rdata, IF_PC <= req_pc, IF_valid <= 1, go HOLD.
- HOLD:
  - While IF_allowin=0, IF outputs hold stable.
  - When IF_allowin=1: IF_valid <= 0, go REQ.
- DROP:
  - inst_req=0.
  - On inst_data_ok: response discarded, go REQ.
- PF_Flush has priority over every other event. It always does PF_PC <= NPC and IF_valid <= 0, then by state:
  - REQ without addr_ok: stay REQ; the new address appears next cycle.
  - REQ with addr_ok the same cycle: the accepted request is stale; PF_PC <= NPC (not sequential), go DROP.
  - WAIT without data_ok: go DROP.
  - WAIT with data_ok the same cycle: data discarded, go REQ.
  - HOLD: buffered instruction discarded, go REQ.
  - DROP: stay DROP; a data_ok the same cycle still retires the stale response, then go REQ.
- PCWr=0 blocks only new requests. Outstanding responses still complete, and flushes still apply.
- No arithmetic internally; NPC is consumed as-is, 32-bit.

## Timing
- Reset (async): state=REQ, PF_PC=RESET_PC, inst_req=0 during reset, IF_valid=0, IF_PC=0, IF_inst=0, IF_adel=0, req_pc=0.
- inst_req and inst_addr are combinational from state, PF_PC and PCWr. inst_addr may change only while not accepted.
- Minimum latency from addr_ok to IF_valid: 1 cycle after data_ok. With zero-wait memory, data_ok comes the cycle after addr_ok.
- Sustained throughput with zero-wait memory and IF_allowin=1: one instruction every 3 cycles (REQ→WAIT→HOLD).
- Redirect latency: the first request to the new target is issued the cycle after PF_Flush, or after the stale data_ok in DROP.
- Reset deasserted mid-transaction: any response arriving in REQ state is ignored. inst_data_ok outside WAIT/DROP is a bus error and is ignored.

## Configuration
- PF_ADEL_CHECK_EN defined:
  - In REQ, if PF_PC[1:0]!=0 and PCWr=1, no inst_req is issued.
  - Instead: IF_valid <= 1, IF_adel <= 1, IF_PC <= PF_PC, IF_inst <= 0, go HOLD.
  - IF_adel clears together with IF_valid.
- Undefined: no alignment check; IF_adel tied 0; misaligned addresses are issued on the bus unchanged.

## Test plan
- Reset release, zero-wait memory, NPC=PF_PC+4:
  - inst_addr sequence BFC00000, BFC00004, BFC00008.
  - IF_PC matches, one IF_valid per 3 cycles.
- IF_allowin=0 for 5 cycles in HOLD: IF_inst/IF_PC stable; no inst_req; resumes one cycle after IF_allowin=1.
- PF_Flush with NPC=BFC00380 in WAIT, data_ok 4 cycles later:
  - the stale data never raises IF_valid.
  - next inst_addr=BFC00380.
- PF_Flush and inst_addr_ok in the same cycle: DROP entered; the next response is discarded; then a fetch to the flush target.
- PCWr=0 held 4 cycles in REQ: inst_req=0, PF_PC unchanged; fetch resumes on PCWr=1.
- With PF_ADEL_CHECK_EN, PF_Flush to 0x80000002: IF_valid=1, IF_adel=1, IF_PC=0x80000002, no bus request.
